pipe_hazard_ctrl: RTL

- Pipeline control unit for the five-stage Y-86 processor (F, D, E, M, W).
- Each cycle it decides stall and bubble controls for every stage register, based on load/use, mispredicted-jump and ret hazards and on exception status.
- A run/drain/halt state machine latches the final processor status and freezes the pipeline.
- Saturating performance counters report total cycles, load/use stalls, mispredicts and ret bubbles.

---
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Y-86 five-stage pipeline control: per-stage stall/bubble decisions,
// run/drain/halt sequencing with final status capture, and saturating event counters.
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_Cnd,
   input  logic [3:0]       M_icode,
   input  logic [3:0]       m_stat,
   input  logic [3:0]       W_stat,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             halted,
   output logic [3:0]       cpu_stat,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] mp_cnt,
   output logic [CNT_W-1:0] ret_cnt
);

   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] R_NONE   = 4'hF;
   localparam logic [3:0] S_AOK    = 4'b1000;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t state, state_nx;
   logic   lu, mp, rt, mexc, wexc, ret_bub, cnt_en;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + 1'b1 : v;
   endfunction

   always_comb begin
      lu   = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      mp   = (E_icode == I_JXX) && !e_Cnd;
      rt   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
      // Any status other than the AOK code, including non-one-hot garbage, is an exception
      mexc = (m_stat != S_AOK);
      wexc = (W_stat != S_AOK);
      // A ret sitting behind a mispredicted jump is squashed, so it is not a ret bubble
      ret_bub = rt && !lu && !mp;
   end

   always_comb begin
      state_nx = state;
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      W_stall  = 1'b0;
      if (rst) begin
         D_bubble = 1'b1;
         E_bubble = 1'b1;
         M_bubble = 1'b1;
      end else begin
         case (state)
            RUN, DRAIN: begin
               F_stall  = lu || rt;
               D_stall  = lu;
               D_bubble = mp || (rt && !lu);
               E_bubble = mp || lu;
               M_bubble = mexc || wexc;
               W_stall  = wexc;
               if (wexc)
                  state_nx = HALTED;
               else if ((state == RUN) && mexc)
                  state_nx = DRAIN;
            end
            HALTED: begin
               F_stall  = 1'b1;
               D_stall  = 1'b1;
               M_bubble = 1'b1;
               W_stall  = 1'b1;
            end
            default: state_nx = RUN;
         endcase
      end
   end

   assign halted = (state == HALTED);
   assign cnt_en = (state != HALTED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         cpu_stat  <= S_AOK;
         cycle_cnt <= '0;
         lu_cnt    <= '0;
         mp_cnt    <= '0;
         ret_cnt   <= '0;
      end else begin
         state <= state_nx;
         if (cnt_en && wexc)
            cpu_stat <= W_stat;
         cycle_cnt <= sat_inc(cycle_cnt, cnt_en);
         lu_cnt    <= sat_inc(lu_cnt,    cnt_en && lu);
         mp_cnt    <= sat_inc(mp_cnt,    cnt_en && mp);
         ret_cnt   <= sat_inc(ret_cnt,   cnt_en && ret_bub);
      end
   end

endmodule
